// File: rtl/loopback_loop_counter.sv
// Loopback probe generator/checker: one tagged, sequence-numbered probe
// in flight at a time; counts round trips, last latency and losses.
module loopback_loop_counter #(
  parameter logic [15:0] PROBE_TAG = 16'hB0A0,
  parameter int unsigned TIMEOUT   = 4096,
  parameter int unsigned GAP       = 16
) (
  input  logic        user_clk,
  input  logic        user_rst_n,
  input  logic        enable,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [63:0] tx_data,
  input  logic        rx_valid,
  input  logic [63:0] rx_data,
  output logic [31:0] loop_cnt,
  output logic [15:0] last_latency,
  output logic [15:0] timeout_cnt,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_GAP
  } state_t;

  localparam logic [15:0] TO_LIM  = 16'(TIMEOUT);
  localparam logic [15:0] GAP_LIM = 16'(GAP);

  state_t      state;
  logic [15:0] seq;
  logic [15:0] lat_ctr;
  logic [15:0] gap_ctr;
  logic        xfer;
  logic        hit;
  logic        rx_unused;

  assign xfer      = tx_valid & tx_ready;
  assign hit       = rx_valid && (rx_data[63:32] == {PROBE_TAG, seq});
  assign rx_unused = ^rx_data[31:0];

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state        <= S_IDLE;
      tx_valid     <= 1'b0;
      tx_data      <= '0;
      loop_cnt     <= '0;
      last_latency <= '0;
      timeout_cnt  <= '0;
      busy         <= 1'b0;
      seq          <= '0;
      lat_ctr      <= '0;
      gap_ctr      <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (enable) begin
            state    <= S_SEND;
            tx_valid <= 1'b1;
            tx_data  <= {PROBE_TAG, seq, 32'h0};
            busy     <= 1'b1;
          end
        end
        S_SEND: begin
          if (xfer) begin
            state    <= S_WAIT;
            tx_valid <= 1'b0;
            lat_ctr  <= 16'd1;
          end else if (!enable) begin
            state    <= S_IDLE;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
          end
        end
        S_WAIT: begin
          // a match on the final cycle wins over the timeout
          if (hit) begin
            loop_cnt     <= loop_cnt + 32'd1;
            last_latency <= lat_ctr;
            seq          <= seq + 16'd1;
            gap_ctr      <= 16'd1;
            state        <= S_GAP;
          end else if (lat_ctr == TO_LIM) begin
            if (timeout_cnt != 16'hFFFF)
              timeout_cnt <= timeout_cnt + 16'd1;
            seq     <= seq + 16'd1;
            gap_ctr <= 16'd1;
            state   <= S_GAP;
          end else begin
            lat_ctr <= lat_ctr + 16'd1;
          end
        end
        S_GAP: begin
          if (gap_ctr == GAP_LIM) begin
            if (enable) begin
              state    <= S_SEND;
              tx_valid <= 1'b1;
              tx_data  <= {PROBE_TAG, seq, 32'h0};
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            gap_ctr <= gap_ctr + 16'd1;
          end
        end
        default: begin
          state    <= S_IDLE;
          tx_valid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
